// File: rtl/match_scoreboard.sv
// Masked reference-vs-DUT result checker with saturating sample/error counters and first-mismatch timestamps.
// Latency 1 cycle (all outputs registered); no backpressure, a sample may be accepted every cycle.
module match_scoreboard #(
  parameter int N_OUT = 2,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   freeze,
  input  logic                   sample_valid,
  input  logic [N_OUT-1:0]       ref_vec,
  input  logic [N_OUT-1:0]       dut_vec,
  input  logic [N_OUT-1:0]       dc_mask,
  output logic [CNT_W-1:0]       sample_count,
  output logic [CNT_W-1:0]       error_count,
  output logic [CNT_W-1:0]       first_error_time,
  output logic [N_OUT*CNT_W-1:0] out_err_count,
  output logic [N_OUT*CNT_W-1:0] out_first_time,
  output logic                   mismatch,
  output logic                   any_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]       timebase_q, timebase_d;
  logic [CNT_W-1:0]       sample_count_q, sample_count_d;
  logic [CNT_W-1:0]       error_count_q, error_count_d;
  logic [CNT_W-1:0]       first_error_time_q, first_error_time_d;
  logic [N_OUT*CNT_W-1:0] out_err_count_q, out_err_count_d;
  logic [N_OUT*CNT_W-1:0] out_first_time_q, out_first_time_d;
  logic                   mismatch_q, mismatch_d;
  logic                   any_error_q, any_error_d;

  logic                   accept;
  logic [N_OUT-1:0]       miss;
  logic                   any_miss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    accept   = sample_valid & ~freeze & ~clear;
    miss     = (ref_vec ^ dut_vec) & ~dc_mask;
    any_miss = |miss;

    timebase_d         = sat_inc(timebase_q);
    sample_count_d     = sample_count_q;
    error_count_d      = error_count_q;
    first_error_time_d = first_error_time_q;
    out_err_count_d    = out_err_count_q;
    out_first_time_d   = out_first_time_q;

    if (clear) begin
      timebase_d         = '0;
      sample_count_d     = '0;
      error_count_d      = '0;
      first_error_time_d = '0;
      out_err_count_d    = '0;
      out_first_time_d   = '0;
    end else if (accept) begin
      sample_count_d = sat_inc(sample_count_q);
      if (any_miss) begin
        error_count_d = sat_inc(error_count_q);
        // A saturated counter is never zero again, so capture only happens once per clear/reset.
        if (error_count_q == '0) first_error_time_d = timebase_q;
      end
      for (int i = 0; i < N_OUT; i++) begin
        if (miss[i]) begin
          out_err_count_d[i*CNT_W +: CNT_W] = sat_inc(out_err_count_q[i*CNT_W +: CNT_W]);
          if (out_err_count_q[i*CNT_W +: CNT_W] == '0)
            out_first_time_d[i*CNT_W +: CNT_W] = timebase_q;
        end
      end
    end

    mismatch_d  = accept & any_miss;
    any_error_d = (error_count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timebase_q         <= '0;
      sample_count_q     <= '0;
      error_count_q      <= '0;
      first_error_time_q <= '0;
      out_err_count_q    <= '0;
      out_first_time_q   <= '0;
      mismatch_q         <= 1'b0;
      any_error_q        <= 1'b0;
    end else begin
      timebase_q         <= timebase_d;
      sample_count_q     <= sample_count_d;
      error_count_q      <= error_count_d;
      first_error_time_q <= first_error_time_d;
      out_err_count_q    <= out_err_count_d;
      out_first_time_q   <= out_first_time_d;
      mismatch_q         <= mismatch_d;
      any_error_q        <= any_error_d;
    end
  end

  assign sample_count     = sample_count_q;
  assign error_count      = error_count_q;
  assign first_error_time = first_error_time_q;
  assign out_err_count    = out_err_count_q;
  assign out_first_time   = out_first_time_q;
  assign mismatch         = mismatch_q;
  assign any_error        = any_error_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Randomized and directed bench for match_scoreboard; a 32-bit and a 4-bit counter instance share stimulus
// and are both compared against an unbounded-count reference model saturated at each instance's width.
module tb_match_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        freeze = 1'b0;
  logic        sample_valid = 1'b0;
  logic [1:0]  ref_vec = '0;
  logic [1:0]  dut_vec = '0;
  logic [1:0]  dc_mask = '0;

  logic [31:0] sc32, ec32, fe32;
  logic [63:0] oe32, of32;
  logic        mm32, ae32;
  logic [3:0]  sc4, ec4, fe4;
  logic [7:0]  oe4, of4;
  logic        mm4, ae4;

  int checks = 0;
  int errors = 0;

  // Reference model: true (unbounded) counts, saturated only when compared.
  longint m_tb, m_n, m_e, m_fe;
  longint m_oe [2];
  longint m_of [2];
  bit     m_mis;

  always #5 clk = ~clk;

  match_scoreboard #(.N_OUT(2), .CNT_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .freeze(freeze), .sample_valid(sample_valid),
    .ref_vec(ref_vec), .dut_vec(dut_vec), .dc_mask(dc_mask),
    .sample_count(sc32), .error_count(ec32), .first_error_time(fe32),
    .out_err_count(oe32), .out_first_time(of32), .mismatch(mm32), .any_error(ae32)
  );

  match_scoreboard #(.N_OUT(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .freeze(freeze), .sample_valid(sample_valid),
    .ref_vec(ref_vec), .dut_vec(dut_vec), .dc_mask(dc_mask),
    .sample_count(sc4), .error_count(ec4), .first_error_time(fe4),
    .out_err_count(oe4), .out_first_time(of4), .mismatch(mm4), .any_error(ae4)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_tb = 0; m_n = 0; m_e = 0; m_fe = 0; m_mis = 0;
    for (int i = 0; i < 2; i++) begin
      m_oe[i] = 0;
      m_of[i] = 0;
    end
  endtask

  task automatic check_all();
    check("sc32", longint'(sc32), sat(m_n, 32));
    check("ec32", longint'(ec32), sat(m_e, 32));
    check("fe32", longint'(fe32), sat(m_fe, 32));
    check("mm32", longint'(mm32), longint'(m_mis));
    check("ae32", longint'(ae32), longint'(m_e != 0));
    check("sc4", longint'(sc4), sat(m_n, 4));
    check("ec4", longint'(ec4), sat(m_e, 4));
    check("fe4", longint'(fe4), sat(m_fe, 4));
    check("mm4", longint'(mm4), longint'(m_mis));
    check("ae4", longint'(ae4), longint'(m_e != 0));
    for (int i = 0; i < 2; i++) begin
      check($sformatf("oe32[%0d]", i), longint'(oe32[i*32 +: 32]), sat(m_oe[i], 32));
      check($sformatf("of32[%0d]", i), longint'(of32[i*32 +: 32]), sat(m_of[i], 32));
      check($sformatf("oe4[%0d]", i), longint'(oe4[i*4 +: 4]), sat(m_oe[i], 4));
      check($sformatf("of4[%0d]", i), longint'(of4[i*4 +: 4]), sat(m_of[i], 4));
    end
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then compare.
  task automatic step(input bit v, input logic [1:0] r, input logic [1:0] d,
                      input logic [1:0] m, input bit fr, input bit cl);
    bit         acc;
    logic [1:0] ms;
    sample_valid = v; ref_vec = r; dut_vec = d; dc_mask = m; freeze = fr; clear = cl;
    @(posedge clk);
    acc = v && !fr && !cl;
    ms  = (r ^ d) & ~m;
    if (cl) begin
      model_reset();
    end else begin
      if (acc) begin
        m_n++;
        if (ms != 0) begin
          if (m_e == 0) m_fe = m_tb;
          m_e++;
        end
        for (int i = 0; i < 2; i++) begin
          if (ms[i]) begin
            if (m_oe[i] == 0) m_of[i] = m_tb;
            m_oe[i]++;
          end
        end
      end
      m_mis = acc && (ms != 0);
      m_tb++;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 0; freeze = 0; clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    check_all();

    // Ten matching samples.
    for (int k = 0; k < 10; k++) step(1, 2'b01, 2'b01, 2'b00, 0, 0);
    check("t1_samples", longint'(sc32), 10);
    check("t1_errors", longint'(ec32), 0);

    // Idle four cycles, then per-bit mismatches at timebase 4 and 5.
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 2'b11, 2'b10, 2'b00, 0, 0);
    check("t2_mm_a", longint'(mm32), 1);
    step(1, 2'b00, 2'b10, 2'b00, 0, 0);
    check("t2_mm_b", longint'(mm32), 1);
    check("t2_errors", longint'(ec32), 2);
    check("t2_first", longint'(fe32), 4);
    check("t2_of0", longint'(of32[31:0]), 4);
    check("t2_of1", longint'(of32[63:32]), 5);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0);
    check("t2_mm_low", longint'(mm32), 0);

    // Don't-care masking.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 2'b00, 2'b11, 2'b11, 0, 0);
    check("t3_errors_dc", longint'(ec32), 0);
    check("t3_samples", longint'(sc32), 5);
    step(1, 2'b00, 2'b11, 2'b01, 0, 0);
    check("t3_errors", longint'(ec32), 1);
    check("t3_oe0", longint'(oe32[31:0]), 0);
    check("t3_oe1", longint'(oe32[63:32]), 1);

    // Freeze for three cycles; timebase keeps running (6,7,8) so the next bit0 miss lands at 9.
    for (int k = 0; k < 3; k++) step(1, 2'b01, 2'b10, 2'b00, 1, 0);
    check("t4_frozen_n", longint'(sc32), 6);
    step(1, 2'b01, 2'b00, 2'b00, 0, 0);
    check("t4_of0", longint'(of32[31:0]), 9);

    // Clear beats a mismatching sample; timebase restarts.
    step(1, 2'b11, 2'b00, 2'b00, 1, 1);
    check("t5_samples", longint'(sc32), 0);
    check("t5_any", longint'(ae32), 0);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 2'b10, 2'b00, 2'b00, 0, 0);
    check("t5_first", longint'(fe32), 1);

    // Saturation of the 4-bit instance.
    do_reset();
    for (int k = 0; k < 17; k++) step(1, 2'b11, 2'b00, 2'b00, 0, 0);
    check("t6_sc4", longint'(sc4), 15);
    check("t6_ec4", longint'(ec4), 15);
    check("t6_fe4", longint'(fe4), 0);
    check("t6_sc32", longint'(sc32), 17);

    // Random traffic with occasional asynchronous resets mid-cycle.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        check("arst_sc32", longint'(sc32), 0);
        check("arst_ec4", longint'(ec4), 0);
        check("arst_oe32", longint'(oe32 != 0), 0);
        check("arst_ae32", longint'(ae32), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 2'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_scoreboard.md
# match_scoreboard

Synthesizable result checker that sits directly downstream of the reference/DUT pair in the alwaysblock test harness. Each sampled point compares the reference output vector against the DUT output vector, with don't-care bits masked. It accumulates total samples, total mismatches, per-output mismatch counts and first-mismatch timestamps. These are the hint and summary statistics the harness reports at end of simulation, produced in hardware so they also run on emulation/FPGA.

## Interface
Parameters:
- N_OUT, 2, number of compared output bits (out_assign, out_alwaysblock → 2)
- CNT_W, 32, width of every counter and timestamp

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all statistics and the timebase
- freeze  in  1  when high, samples are ignored and counters hold
- sample_valid  in  1  ref_vec/dut_vec/dc_mask valid this cycle
- ref_vec  in  N_OUT  reference outputs
- dut_vec  in  N_OUT  DUT outputs
- dc_mask  in  N_OUT  1 = reference bit is don't-care (matches anything)
- sample_count  out  CNT_W  accepted samples
- error_count  out  CNT_W  samples with any unmasked mismatch
- first_error_time  out  CNT_W  timebase value at first mismatching sample
- out_err_count  out  N_OUT*CNT_W  per-bit mismatch counts, bit i at [i*CNT_W +: CNT_W]
- out_first_time  out  N_OUT*CNT_W  per-bit first-mismatch timestamps, same packing
- mismatch  out  1  registered pulse: previous accepted sample mismatched
- any_error  out  1  sticky: error_count != 0

## Operation
- Timebase: free-running CNT_W counter. Increments every cycle and is not gated by freeze. Saturates at all-ones.
- Accept = sample_valid & ~freeze & ~clear.
- Per-bit mismatch: miss[i] = (ref_vec[i] ^ dut_vec[i]) & ~dc_mask[i]. Sample mismatch = |miss.
- On accept:
  - sample_count += 1.
  - If |miss: error_count += 1. If error_count was 0, capture first_error_time = current timebase.
  - For each i with miss[i]: out_err_count[i] += 1. If that count was 0, capture out_first_time[i] = timebase.
- All counters saturate at 2^CNT_W-1 and never wrap. A saturated count does not re-arm first-time capture.
- mismatch <= accept & |miss each cycle. It is 0 in any cycle with no accept.
- any_error <= (error_count_next != 0).
- clear: zeroes every output, counter and the timebase on the next edge. clear beats sample_valid in the same cycle; that sample is dropped.
- freeze: all statistics hold. Timebase keeps running. mismatch is 0.
- Reset: all outputs 0, timebase 0.

## Timing
- All outputs registered. A sample accepted at edge k is reflected in every output after edge k, so latency is 1 cycle.
- Timestamp captured = timebase value sampled at edge k, i.e. the count of edges since reset/clear before edge k. The first edge after reset sees timebase 0.
- No backpressure. A sample may be accepted every cycle.
- rst_n assertion mid-run clears immediately, asynchronously. Deassertion is synchronized externally; the first active edge after release counts as timebase 0.
- Simultaneous clear and freeze: clear wins.

## Test plan
- Reset then 10 matching samples (ref=dut=2'b01, dc=0) → sample_count=10, error_count=0, any_error=0, mismatch never 1.
- After reset, idle 4 cycles, then samples ref=2'b11/dut=2'b10 (bit0 miss) at timebase 4 and ref=2'b00/dut=2'b10 (bit1 miss) at timebase 5 → error_count=2, first_error_time=4, out_err_count[0]=1, out_err_count[1]=1, out_first_time[0]=4, out_first_time[1]=5, mismatch high one cycle after each.
- dc_mask=2'b11 with ref=2'b00, dut=2'b11 for 5 samples → error_count=0, sample_count=5. Then dc_mask=2'b01, same vectors → error_count=1, only out_err_count[1]=1.
- freeze high for 3 cycles with mismatching valid samples → counters unchanged. A mismatch after freeze drops records timestamp including the frozen cycles (timebase advanced by 3).
- clear and mismatching sample_valid in the same cycle → all outputs 0 next cycle, sample dropped, timebase restarts at 0.
- CNT_W=4: 17 mismatching samples → sample_count=error_count=15 (saturated), first_error_time unchanged from first capture. Assert rst_n low mid-run → all outputs 0 immediately.
